// File: rtl/branch_seq.sv
// Branch resolution sequencer: borrows the shared EX-stage ALU for one compare
// cycle and one next-PC cycle, then presents taken/target to PC select.
module branch_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic [3:0]      alu_op,
    output logic            alu_use_imm,
    output logic            alu_op_choice,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic [XLEN-1:0] alu_imm,
    output logic [XLEN-1:0] alu_pc,
    input  logic [XLEN-1:0] alu_dest,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic            illegal,
    output logic            misaligned
);

    typedef enum logic [1:0] {IDLE, CMP, TGT, DONE} state_t;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SLT   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_AUIPC = 4'b1010;

    state_t          state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] src1_q, src1_d, src2_q, src2_d, imm_q, imm_d, pc_q, pc_d;
    logic            cond_q, cond_d;
    logic            taken_q, taken_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            illegal_q, illegal_d;
    logic            misaligned_q, misaligned_d;
    logic            out_valid_q, out_valid_d;
    logic            cmp_eq, cmp_lt, cmp_cond;

    // ALU is driven only while a branch owns it; idle/done cycles leave it zeroed.
    always_comb begin
        alu_op        = OP_ADD;
        alu_use_imm   = 1'b0;
        alu_op_choice = 1'b0;
        alu_src1      = '0;
        alu_src2      = '0;
        alu_imm       = '0;
        alu_pc        = '0;
        case (state_q)
            CMP: begin
                alu_src1 = src1_q;
                alu_src2 = src2_q;
                case (funct3_q)
                    3'b000, 3'b001: alu_op = OP_XOR;
                    3'b100, 3'b101: alu_op = OP_SLT;
                    3'b110, 3'b111: alu_op = OP_SLTU;
                    default:        alu_op = OP_ADD;
                endcase
            end
            TGT: begin
                alu_use_imm = 1'b1;
                if (cond_q) begin
                    alu_op  = OP_AUIPC;
                    alu_imm = imm_q;
                    alu_pc  = pc_q;
                end else begin
                    alu_op   = OP_ADD;
                    alu_src1 = pc_q;
                    alu_imm  = XLEN'(4);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cmp_eq = (alu_dest == '0);
        cmp_lt = alu_dest[0];
        case (funct3_q)
            3'b000:         cmp_cond = cmp_eq;
            3'b001:         cmp_cond = !cmp_eq;
            3'b100, 3'b110: cmp_cond = cmp_lt;
            3'b101, 3'b111: cmp_cond = !cmp_lt;
            default:        cmp_cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        cond_d       = cond_q;
        taken_d      = taken_q;
        target_d     = target_q;
        illegal_d    = illegal_q;
        misaligned_d = misaligned_q;
        out_valid_d  = out_valid_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    funct3_d  = funct3;
                    src1_d    = src1;
                    src2_d    = src2;
                    imm_d     = imm;
                    pc_d      = pc;
                    illegal_d = 1'b0;
                    state_d   = CMP;
                end
                CMP: begin
                    cond_d    = cmp_cond;
                    illegal_d = (funct3_q[2:1] == 2'b01);
                    state_d   = TGT;
                end
                TGT: begin
                    target_d     = alu_dest;
                    taken_d      = cond_q;
                    misaligned_d = cond_q && (alu_dest[1:0] != 2'b00);
                    out_valid_d  = 1'b1;
                    state_d      = DONE;
                end
                DONE: if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            funct3_q     <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            imm_q        <= '0;
            pc_q         <= '0;
            cond_q       <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= '0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            funct3_q     <= funct3_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            cond_q       <= cond_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
            illegal_q    <= illegal_d;
            misaligned_q <= misaligned_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign taken      = taken_q;
    assign target     = target_q;
    assign illegal    = illegal_q;
    assign misaligned = misaligned_q;

endmodule
